add_serial_nb: RTL
==================

# add_serial_nb

Parametrised digit-serial adder. It adds two WIDTH-bit operands plus a carry-in over WIDTH/DIGIT clock cycles, one DIGIT-bit slice per cycle, and uses valid/ready handshakes on both input and output. It is the sequential, area-scalable successor to the single-cycle 1-bit full-adder cell, and it sits in the datapath wherever a wide add can trade latency for ripple depth.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A, two's complement or unsigned
- B  input  WIDTH  operand B
- Cin  input  1  carry-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  sum
- Cout  output  1  carry-out of the MSB
- Ovf  output  1  signed overflow flag

## Operation
- NDIG = WIDTH/DIGIT. The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1 (forced 0 while rst is high).
  - When in_valid && in_ready at a clock edge, the block latches A, B and Cin, clears the digit counter, and goes to RUN.
- RUN:
  - Each edge adds digit[cnt] of A and B plus the carry register.
  - The DIGIT-bit result is written into S[cnt*DIGIT +: DIGIT], the carry register is updated, and cnt increments.
  - On the edge that processes cnt == NDIG-1, the block loads Cout and Ovf and goes to DONE.
- DONE:
  - out_valid = 1. S, Cout and Ovf are held stable.
  - When out_ready is high at an edge, out_valid drops and the FSM returns to IDLE.
- A, B and Cin are sampled only on the accept edge; changes during RUN or DONE are ignored.
- Arithmetic is modulo 2^WIDTH. Cout equals bit WIDTH of A+B+Cin.
- Ovf = (carry into MSB) XOR Cout, which equals signed overflow.
- Only one operation is in flight at a time.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - out_valid = 0, S = 0, Cout = 0, Ovf = 0.
  - in_ready = 0 during reset, and 1 in the first cycle after rst deasserts.
- Latency: out_valid rises NDIG edges after the accept edge. With the defaults (NDIG = 4) this is 4 cycles.
- Throughput: at most one operation per NDIG+2 cycles. in_ready returns in the cycle after the out_valid && out_ready edge.
- Backpressure: out_valid and the outputs hold indefinitely while out_ready = 0, and in_ready stays 0.
- out_ready is ignored outside DONE.
- in_valid high outside IDLE is ignored; nothing is queued.
- Reset mid-operation aborts immediately:
  - All outputs go to their reset values and the partial result is discarded.
  - No out_valid is produced for the aborted operation.
- NDIG = 1 (DIGIT = WIDTH) is legal: the result appears one edge after accept.

## Configuration
- ADD_SERIAL_OVF_EN defined: the Ovf register and the carry-into-MSB tap are built, and Ovf behaves as in Operation.
- ADD_SERIAL_OVF_EN undefined: the Ovf port still exists and is tied to 0, and no overflow logic is synthesised. All other behaviour is identical.

## Structure
- Package add_pkg holds:
  - the FSM state enum typedef (IDLE/RUN/DONE);
  - the NDIG computation as a constant function;
  - a counter-width function, clog2(NDIG) with a minimum of 1.
- Sub-module add_digit: a DIGIT-bit combinational ripple built from the existing 1-bit full-adder cell.
  - Outputs: sum, carry-out, and the carry into its top bit (used for Ovf).
- add_serial_nb holds the FSM, the digit counter, the operand shift registers, the carry register and the result register.

## Test plan
- Defaults, A=0xFFFF, B=0x0001, Cin=0 → after 4 cycles S=0x0000, Cout=1, Ovf=0.
- A=0x7FFF, B=0x0001, Cin=0 → S=0x8000, Cout=0, Ovf=1 (with ADD_SERIAL_OVF_EN; Ovf=0 without it).
- A=0x0000, B=0x0000, Cin=1 → S=0x0001, Cout=0. Also, A=0x1234, B=0x4321 are changed mid-RUN → S=0x5555, the latched values are used.
- Result pending, out_ready held 0 for 5 cycles → out_valid=1 and S stable throughout, in_ready=0. in_ready=1 the cycle after the handshake.
- rst pulsed at RUN cnt=2 → out_valid never asserts, all outputs are 0, in_ready=1 after release. The next operation 0x0003+0x0004 gives S=0x0007.
- WIDTH=4 with DIGIT=1 and DIGIT=4, all 512 {A, B, Cin} combinations back-to-back with random out_ready → S, Cout and Ovf match the behavioural A+B+Cin in every case; zero errors reported.

Source files
------------

// File: rtl/add_pkg.sv
// ============================================================================
// Module   : add_pkg
// Purpose  : Shared types and sizing helpers for the digit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } add_state_t;

    function automatic int add_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter must stay at least one bit wide even when a single digit covers the word.
    function automatic int add_cnt_w(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

`default_nettype wire

// File: rtl/add_digit.sv
// ============================================================================
// Module   : add_digit
// Purpose  : DIGIT-bit ripple adder built from full_adder cells; also exposes
//            the carry into its top bit for signed-overflow detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout  = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module   : full_adder
// Purpose  : Single-bit combinational full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/add_serial_nb.sv
// ============================================================================
// Module   : add_serial_nb
// Purpose  : Digit-serial WIDTH-bit adder with valid/ready handshakes.
//            Optional macro ADD_SERIAL_OVF_EN builds the signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_serial_nb
    import add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int c_ndig  = add_ndig(WIDTH, DIGIT);
    localparam int c_cnt_w = add_cnt_w(c_ndig);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_ndig - 1);

    add_state_t         r_state;
    add_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;

    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcout;
    logic               w_c_msb;
    logic               w_accept;
    logic               w_last;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_state == ST_RUN) && (r_cnt == c_last);

    add_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .sum   (w_dsum),
        .cout  (w_dcout),
        .c_msb (w_c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands shift right so the active digit always sits in the low bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
        end else if (r_state == ST_RUN) begin
            r_cnt   <= r_cnt + c_cnt_w'(1);
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dcout;
            for (int i = 0; i < c_ndig; i++) begin
                if (r_cnt == c_cnt_w'(i)) begin
                    r_s[i*DIGIT +: DIGIT] <= w_dsum;
                end
            end
            if (w_last) begin
                r_cout <= w_dcout;
            end
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

`ifdef ADD_SERIAL_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_c_msb ^ w_dcout;
        end
    end

    assign Ovf = r_ovf;
`else
    logic w_unused_c_msb;

    assign w_unused_c_msb = w_c_msb;
    assign Ovf            = 1'b0;
`endif

endmodule

`default_nettype wire
